machine_timer: RTL and testbench
================================

MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 SHALL have parameter CMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF, giving the reset value of MTIMECMP.
REQ-002 SHALL have port clk, input, 1, the system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sel, input, 1, address-decoder select for this peripheral.
REQ-005 SHALL have port we, input, 1, write enable, taken from the CPU data-port write strobe.
REQ-006 SHALL have port addr, input, 5, byte offset in the register window; bits [1:0] are ignored.
REQ-007 SHALL have port wrMask, input, 4, byte write enables; bit n enables data bits [8n+7:8n].
REQ-008 SHALL have port wrData, input, 32, write data, already lane-aligned.
REQ-009 SHALL have port rdData, output, 32, combinational read data.
REQ-010 SHALL have port irq, output, 1, level timer interrupt to the interrupt-controller irqBus.

Function
REQ-011 SHALL implement this register map: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL, 0x14 STATUS.
REQ-012 SHALL return 0 on rdData for offsets 0x18-0x1C and whenever sel=0.
REQ-013 SHALL define CTRL as: bit0 EN (count enable), bit1 IE (interrupt enable), bits[15:8] PRESC; all other bits read 0 and ignore writes.
REQ-014 SHALL define STATUS as: bit0 PEND, write-1-to-clear; all other bits read 0.
REQ-015 SHALL present reads the same cycle, with no wait state, reflecting register values before the clock edge.
REQ-016 SHALL commit a write at the edge where sel=1 and we=1, updating only the bytes whose wrMask bit is set.
REQ-017 SHALL run an 8-bit prescaler count (PCNT) while EN=1: when PCNT==PRESC, PCNT<=0 and MTIME increments by 1; otherwise PCNT increments.
REQ-018 SHALL, with PRESC=0, increment MTIME every cycle.
REQ-019 SHALL hold PCNT and MTIME while EN=0; clearing EN SHALL NOT reset PCNT.
REQ-020 SHALL treat MTIME as a 64-bit unsigned count that wraps from 2^64-1 to 0 with no flag.
REQ-021 SHALL carry the LO-to-HI increment within the same cycle.
REQ-022 SHALL, on a write to MTIME_LO or MTIME_HI, let the written bytes take the write value, leave other bytes at their pre-edge value, and suppress the increment of all 64 bits that cycle.
REQ-023 SHALL NOT alter PCNT on an MTIME write.
REQ-024 SHALL, on a PRESC write, take the new value from the next cycle; if PCNT > new PRESC, PCNT counts up and wraps at 255 to 0.
REQ-025 SHALL evaluate the compare each cycle as unsigned 64-bit MTIME >= MTIMECMP, using pre-edge register values.
REQ-026 SHALL set PEND at the edge following a cycle in which the compare is true, regardless of EN or IE.
REQ-027 SHALL clear PEND when a write to STATUS has wrMask[0]=1 and wrData[0]=1; if set and clear occur in the same cycle, set wins.
REQ-028 SHALL drive irq = PEND & IE, combinational from registers and free of glitches from bus inputs.
REQ-029 SHALL let the compare on the new MTIMECMP take effect in the cycle after a MTIMECMP write.

Reset
REQ-030 SHALL reset on the edge with reset=1: MTIME=0, MTIMECMP=CMP_RESET, CTRL=0, PCNT=0, PEND=0, so irq=0.
REQ-031 SHALL give reset priority over any same-cycle write or increment.
REQ-032 SHALL, on reset mid-count, leave no residual prescaler phase.

Verification
REQ-033 SHALL test prescaled count: CTRL=0x0301, MTIME=0 -> MTIME_LO reads 1 after 4 cycles and 5 after 20 cycles.
REQ-034 SHALL test the carry: MTIME_LO=0xFFFF_FFFF, MTIME_HI=0, CTRL=0x0001 -> next cycle LO=0, HI=1.
REQ-035 SHALL test the compare interrupt: MTIMECMP=10, CTRL=0x0003, MTIME=0 -> PEND=1 and irq=1 in the cycle after MTIME reaches 10; W1C STATUS with MTIMECMP still 10 -> PEND stays 1 (set wins); write MTIMECMP_HI=1 then W1C -> PEND=0, irq=0.
REQ-036 SHALL test a masked write: MTIMECMP_LO=0xFFFF_FFFF, write wrData=0x0000_1200 with wrMask=4'b0010 -> reads 0xFFFF_12FF.
REQ-037 SHALL test write-versus-increment priority: EN=1, PRESC=0, write MTIME_LO=0x100 -> reads 0x100 the next cycle and 0x101 the cycle after.
REQ-038 SHALL test reset mid-operation: reset asserted with PEND=1, MTIME=0x55, CTRL=0x0203 -> all registers at reset values and irq=0 the cycle after.

Source files
------------

// File: rtl/machine_timer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : machine_timer_if
// Description : Register-bus and interrupt bundle for the machine timer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface machine_timer_if;
    logic        sel;
    logic        we;
    logic [4:0]  addr;
    logic [3:0]  wrMask;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        irq;

    modport master (
        output sel, we, addr, wrMask, wrData,
        input  rdData, irq
    );

    modport slave (
        input  sel, we, addr, wrMask, wrData,
        output rdData, irq
    );
endinterface
`default_nettype wire

// File: rtl/machine_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : machine_timer
// Description : 64-bit prescaled machine timer with compare and level interrupt.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module machine_timer #(
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  wire logic      clk,
    input  wire logic      reset,
    machine_timer_if.slave bus
);

    localparam logic [2:0] c_MTIME_LO = 3'd0;
    localparam logic [2:0] c_MTIME_HI = 3'd1;
    localparam logic [2:0] c_CMP_LO   = 3'd2;
    localparam logic [2:0] c_CMP_HI   = 3'd3;
    localparam logic [2:0] c_CTRL     = 3'd4;
    localparam logic [2:0] c_STATUS   = 3'd5;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic        r_ie;
    logic [7:0]  r_presc;
    logic [7:0]  r_pcnt;
    logic        r_pend;

    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_wrMtLo;
    logic        w_wrMtHi;
    logic        w_wrCmpLo;
    logic        w_wrCmpHi;
    logic        w_wrCtrl;
    logic        w_pendClr;
    logic        w_tick;
    logic        w_cmpHit;
    logic [31:0] w_laneMask;
    logic [63:0] w_mtimeNext;
    logic [31:0] w_rdData;
    logic        w_unusedAddr;

    assign w_idx        = bus.addr[4:2];
    assign w_unusedAddr = ^bus.addr[1:0];
    assign w_wr         = bus.sel & bus.we;
    assign w_wrMtLo     = w_wr && (w_idx == c_MTIME_LO);
    assign w_wrMtHi     = w_wr && (w_idx == c_MTIME_HI);
    assign w_wrCmpLo    = w_wr && (w_idx == c_CMP_LO);
    assign w_wrCmpHi    = w_wr && (w_idx == c_CMP_HI);
    assign w_wrCtrl     = w_wr && (w_idx == c_CTRL);
    assign w_pendClr    = w_wr && (w_idx == c_STATUS) && bus.wrMask[0] && bus.wrData[0];

    // Expand the byte enables into a per-bit mask for read-modify-write merges.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_laneMask
            assign w_laneMask[8*gi +: 8] = {8{bus.wrMask[gi]}};
        end
    endgenerate

    function automatic logic [31:0] f_merge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [31:0] mask);
        f_merge = (oldVal & ~mask) | (newVal & mask);
    endfunction

    assign w_tick   = r_en && (r_pcnt == r_presc);
    assign w_cmpHit = (r_mtime >= r_mtimecmp);

    // A bus write to either half freezes the whole 64-bit count for that cycle.
    always_comb begin
        w_mtimeNext = r_mtime;
        if (w_wrMtLo) begin
            w_mtimeNext[31:0] = f_merge(r_mtime[31:0], bus.wrData, w_laneMask);
        end else if (w_wrMtHi) begin
            w_mtimeNext[63:32] = f_merge(r_mtime[63:32], bus.wrData, w_laneMask);
        end else if (w_tick) begin
            w_mtimeNext = r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= CMP_RESET;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_presc    <= 8'd0;
            r_pcnt     <= 8'd0;
            r_pend     <= 1'b0;
        end else begin
            r_mtime <= w_mtimeNext;

            // A prescaler that overshoots a newly lowered PRESC wraps through 255.
            if (r_en) begin
                r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;
            end

            if (w_wrCmpLo) begin
                r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], bus.wrData, w_laneMask);
            end
            if (w_wrCmpHi) begin
                r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], bus.wrData, w_laneMask);
            end

            if (w_wrCtrl && bus.wrMask[0]) begin
                r_en <= bus.wrData[0];
                r_ie <= bus.wrData[1];
            end
            if (w_wrCtrl && bus.wrMask[1]) begin
                r_presc <= bus.wrData[15:8];
            end

            if (w_cmpHit) begin
                r_pend <= 1'b1;
            end else if (w_pendClr) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdData = 32'd0;
        if (bus.sel) begin
            case (w_idx)
                c_MTIME_LO: w_rdData = r_mtime[31:0];
                c_MTIME_HI: w_rdData = r_mtime[63:32];
                c_CMP_LO:   w_rdData = r_mtimecmp[31:0];
                c_CMP_HI:   w_rdData = r_mtimecmp[63:32];
                c_CTRL:     w_rdData = {16'd0, r_presc, 6'd0, r_ie, r_en};
                c_STATUS:   w_rdData = {31'd0, r_pend};
                default:    w_rdData = 32'd0;
            endcase
        end
    end

    assign bus.rdData = w_rdData;
    assign bus.irq    = r_pend & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_machine_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_machine_timer
// Description : Self-checking bench for machine_timer: reference model plus
//               directed scenarios with hand-computed expectations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_machine_timer;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    machine_timer_if bus();

    machine_timer #(.CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int nCmp = 0;
    int nBad = 0;

    // Reference model state
    logic [63:0] mMtime;
    logic [63:0] mCmp;
    logic        mEn, mIe, mPend;
    logic [7:0]  mPresc, mPcnt;
    bit          mValid = 1'b0;

    function automatic logic [31:0] mergeWord(input logic [31:0] o, input logic [31:0] d,
                                              input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function logic [31:0] modelRead(input logic s, input logic [4:0] a);
        if (!s) return 32'd0;
        case (a[4:2])
            3'd0:    return mMtime[31:0];
            3'd1:    return mMtime[63:32];
            3'd2:    return mCmp[31:0];
            3'd3:    return mCmp[63:32];
            3'd4:    return {16'd0, mPresc, 6'd0, mIe, mEn};
            3'd5:    return {31'd0, mPend};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : p_model
        logic        hit, wr, clr;
        logic [2:0]  idx;
        logic [63:0] nxt;
        if (reset) begin
            mMtime = 64'd0; mCmp = 64'hFFFF_FFFF_FFFF_FFFF;
            mEn = 1'b0; mIe = 1'b0; mPresc = 8'd0; mPcnt = 8'd0; mPend = 1'b0;
            mValid = 1'b1;
        end else begin
            hit = (mMtime >= mCmp);
            wr  = bus.sel && bus.we;
            idx = bus.addr[4:2];
            clr = wr && idx == 3'd5 && bus.wrMask[0] && bus.wrData[0];
            nxt = mMtime;
            if (wr && idx == 3'd0)      nxt[31:0]  = mergeWord(mMtime[31:0], bus.wrData, bus.wrMask);
            else if (wr && idx == 3'd1) nxt[63:32] = mergeWord(mMtime[63:32], bus.wrData, bus.wrMask);
            else if (mEn && mPcnt == mPresc) nxt = mMtime + 64'd1;
            if (mEn) mPcnt = (mPcnt == mPresc) ? 8'd0 : mPcnt + 8'd1;
            mMtime = nxt;
            if (wr && idx == 3'd2) mCmp[31:0]  = mergeWord(mCmp[31:0], bus.wrData, bus.wrMask);
            if (wr && idx == 3'd3) mCmp[63:32] = mergeWord(mCmp[63:32], bus.wrData, bus.wrMask);
            if (wr && idx == 3'd4) begin
                if (bus.wrMask[0]) begin mEn = bus.wrData[0]; mIe = bus.wrData[1]; end
                if (bus.wrMask[1]) mPresc = bus.wrData[15:8];
            end
            mPend = hit ? 1'b1 : (clr ? 1'b0 : mPend);
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            nCmp++;
            if (bus.rdData !== modelRead(bus.sel, bus.addr)) begin
                nBad++;
                $display("FAIL model_rdData addr=%h got=%h want=%h", bus.addr, bus.rdData,
                         modelRead(bus.sel, bus.addr));
            end
            nCmp++;
            if (bus.irq !== (mPend & mIe)) begin
                nBad++;
                $display("FAIL model_irq got=%b want=%b", bus.irq, mPend & mIe);
            end
        end
    end

    task automatic expectRead(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a; bus.wrMask = 4'h0;
        #1;
        nCmp++;
        if (bus.rdData !== exp) begin
            nBad++;
            $display("FAIL %s got=%h want=%h", name, bus.rdData, exp);
        end
    endtask

    task automatic expectIrq(input string name, input logic exp);
        #1;
        nCmp++;
        if (bus.irq !== exp) begin
            nBad++;
            $display("FAIL %s got=%b want=%b", name, bus.irq, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wrData = d; bus.wrMask = m;
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.sel = 1'b0; bus.we = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        bus.sel = 1'b0; bus.we = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 5'd0; bus.wrMask = 4'h0; bus.wrData = 32'd0;
        doReset();

        // Reset values
        expectRead("rst_mtime_lo", 5'h00, 32'h0);
        expectRead("rst_mtime_hi", 5'h04, 32'h0);
        expectRead("rst_cmp_lo",   5'h08, 32'hFFFF_FFFF);
        expectRead("rst_cmp_hi",   5'h0C, 32'hFFFF_FFFF);
        expectRead("rst_ctrl",     5'h10, 32'h0);
        expectRead("rst_status",   5'h14, 32'h0);
        expectIrq("rst_irq", 1'b0);
        idle(1);
        expectRead("hole_18", 5'h18, 32'h0);
        bus.sel = 1'b0; bus.addr = 5'h08;
        #1;
        nCmp++;
        if (bus.rdData !== 32'h0) begin
            nBad++;
            $display("FAIL unselected_read got=%h want=%h", bus.rdData, 32'h0);
        end

        // Prescaled count, PRESC=3
        wr(5'h10, 32'h0000_0301, 4'hF);
        idle(3);
        expectRead("presc3_after3", 5'h00, 32'd0);
        idle(1);
        expectRead("presc3_after4", 5'h00, 32'd1);
        idle(16);
        expectRead("presc3_after20", 5'h00, 32'd5);

        // LO-to-HI carry
        doReset();
        wr(5'h00, 32'hFFFF_FFFF, 4'hF);
        wr(5'h10, 32'h0000_0001, 4'hF);
        expectRead("carry_pre_lo", 5'h00, 32'hFFFF_FFFF);
        idle(1);
        expectRead("carry_lo", 5'h00, 32'h0);
        expectRead("carry_hi", 5'h04, 32'h1);

        // Compare interrupt and set-wins-over-clear
        doReset();
        wr(5'h08, 32'd10, 4'hF);
        wr(5'h0C, 32'd0, 4'hF);
        wr(5'h10, 32'h0000_0003, 4'hF);
        idle(10);
        expectRead("cmp_mtime10", 5'h00, 32'd10);
        expectRead("cmp_pend_early", 5'h14, 32'd0);
        expectIrq("cmp_irq_early", 1'b0);
        idle(1);
        expectRead("cmp_pend_set", 5'h14, 32'd1);
        expectIrq("cmp_irq_set", 1'b1);
        wr(5'h14, 32'd1, 4'h1);
        expectRead("cmp_set_wins", 5'h14, 32'd1);
        wr(5'h0C, 32'd1, 4'hF);
        wr(5'h14, 32'd1, 4'h1);
        expectRead("cmp_cleared", 5'h14, 32'd0);
        expectIrq("cmp_irq_cleared", 1'b0);

        // Masked write to MTIMECMP_LO
        wr(5'h08, 32'hFFFF_FFFF, 4'hF);
        wr(5'h08, 32'h0000_1200, 4'b0010);
        expectRead("masked_cmp_lo", 5'h08, 32'hFFFF_12FF);

        // Write beats increment, then EN=0 holds the count
        doReset();
        wr(5'h10, 32'h0000_0001, 4'hF);
        wr(5'h00, 32'h0000_0100, 4'hF);
        expectRead("wr_prio_0", 5'h00, 32'h100);
        idle(1);
        expectRead("wr_prio_1", 5'h00, 32'h101);
        wr(5'h10, 32'h0, 4'hF);
        idle(5);
        expectRead("en_hold", 5'h00, 32'h102);

        // Lowering PRESC below the live prescaler count forces a wrap through 255
        doReset();
        wr(5'h10, 32'h0000_0501, 4'hF);
        idle(4);
        wr(5'h10, 32'h0000_0201, 4'hF);
        idle(253);
        expectRead("presc_wrap_253", 5'h00, 32'd0);
        idle(1);
        expectRead("presc_wrap_254", 5'h00, 32'd1);

        // Reset mid-operation, overriding a same-cycle write
        doReset();
        wr(5'h08, 32'd0, 4'hF);
        wr(5'h0C, 32'd0, 4'hF);
        wr(5'h00, 32'h55, 4'hF);
        wr(5'h10, 32'h0000_0203, 4'hF);
        expectRead("mid_pend", 5'h14, 32'd1);
        expectIrq("mid_irq", 1'b1);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 5'h00; bus.wrData = 32'h1234; bus.wrMask = 4'hF;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.sel = 1'b0; bus.we = 1'b0;
        expectRead("mid_rst_mtime_lo", 5'h00, 32'h0);
        expectRead("mid_rst_cmp_lo",   5'h08, 32'hFFFF_FFFF);
        expectRead("mid_rst_ctrl",     5'h10, 32'h0);
        expectRead("mid_rst_status",   5'h14, 32'h0);
        expectIrq("mid_rst_irq", 1'b0);
        idle(3);
        expectRead("mid_rst_hold", 5'h00, 32'h0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
